// File: rtl/sandbox_channel_router_if.sv
// ---------------------------------------------------------------------------
// sandbox_channel_router_if
// Bundles the host side (WideUARTIO command/response handshake) and the
// channel side (start/done/status/result of each sandbox process) of the
// channel router.
//   master : host + channel processes (drive commands, UART busy, results)
//   slave  : the router (drives acknowledges, requests, starts, latches)
// Ports:
//   dataReceived/control/inputData -> host command, clearDR <- consumed
//   transmitting -> UART busy, txRequest/status/outputData <- response
//   chStart/chControl/chInputData <- command to channels
//   chDone/chStatus/chOutputData -> per-channel completion
//   busy <- command outstanding
// ---------------------------------------------------------------------------
interface sandbox_channel_router_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  logic                            dataReceived;
  logic [7:0]                      control;
  logic [8*WIDTH-1:0]              inputData;
  logic                            clearDR;
  logic                            transmitting;
  logic                            txRequest;
  logic [7:0]                      status;
  logic [8*WIDTH-1:0]              outputData;
  logic [CHANNELS-1:0]             chStart;
  logic [7:0]                      chControl;
  logic [8*WIDTH-1:0]              chInputData;
  logic [CHANNELS-1:0]             chDone;
  logic [8*CHANNELS-1:0]           chStatus;
  logic [8*WIDTH*CHANNELS-1:0]     chOutputData;
  logic                            busy;

  modport master (
    output dataReceived, control, inputData, transmitting,
           chDone, chStatus, chOutputData,
    input  clearDR, txRequest, status, outputData,
           chStart, chControl, chInputData, busy
  );

  modport slave (
    input  dataReceived, control, inputData, transmitting,
           chDone, chStatus, chOutputData,
    output clearDR, txRequest, status, outputData,
           chStart, chControl, chInputData, busy
  );
endinterface

// File: rtl/sandbox_channel_router.sv
// ---------------------------------------------------------------------------
// sandbox_channel_router
// Routes host commands to one of CHANNELS sandbox processes selected by
// control[3:0], waits for that channel's completion (or a timeout), and
// queues a tagged response {channel, code} + payload in a FIFO that is
// drained to the UART transmitter one word per txRequest handshake.
// Ports:
//   masterClock : single clock
//   reset       : synchronous, active-high
//   bus         : sandbox_channel_router_if.slave (host + channel signals)
//
// Command FSM
//   state  | meaning
//   C_IDLE | waiting for dataReceived; acknowledges and latches command
//   C_WAIT | channel started, waiting for its chDone or the timeout
//   C_PUSH | response ready, written to FIFO as soon as there is room
// TX FSM
//   state  | meaning
//   T_IDLE | pops FIFO head when transmitter idle, pulses txRequest
//   T_REQ  | waiting for transmitter to go busy
//   T_BUSY | waiting for transmitter to finish
// ---------------------------------------------------------------------------
module sandbox_channel_router #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 8,
  parameter int TIMEOUT  = 12000000
) (
  input  logic                      masterClock,
  input  logic                      reset,
  sandbox_channel_router_if.slave   bus
);

  localparam int DW = 8 * WIDTH;
  localparam int RW = 8 + DW;
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {C_IDLE, C_WAIT, C_PUSH} cmd_state_t;
  typedef enum logic [1:0] {T_IDLE, T_REQ, T_BUSY} tx_state_t;

  cmd_state_t cmd_state, cmd_next;
  tx_state_t  tx_state, tx_next;

  // command datapath
  logic                 clear_dr_q;
  logic [CHANNELS-1:0]  ch_start_q;
  logic [7:0]           ch_control_q;
  logic [DW-1:0]        ch_input_q;
  logic                 busy_q;
  logic [3:0]           cur_idx;
  logic [TW-1:0]        timer;
  logic [7:0]           resp_tag;
  logic [DW-1:0]        resp_data;

  // tx datapath
  logic                 tx_request_q;
  logic [7:0]           status_q;
  logic [DW-1:0]        output_q;

  // fifo
  logic [RW-1:0]        fifo_mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          fifo_count;
  logic                 fifo_full, fifo_empty;

  // decoded controls
  logic                 accept, idx_valid, done_hit, tmo_hit;
  logic                 fifo_push, fifo_pop;
  logic [CHANNELS-1:0]  start_onehot;
  logic                 sel_done;
  logic [3:0]           sel_code;
  logic [DW-1:0]        sel_data;

  assign idx_valid    = bus.control[3:0] < 4'(CHANNELS);
  assign start_onehot = CHANNELS'(1) << bus.control[3:0];
  assign fifo_full    = fifo_count == (AW + 1)'(DEPTH);
  assign fifo_empty   = fifo_count == '0;

  // Only the channel currently waited on is looked at; other chDone pulses
  // fall through unused.
  always_comb begin
    sel_done = 1'b0;
    sel_code = 4'h0;
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cur_idx == 4'(i)) begin
        sel_done = bus.chDone[i];
        sel_code = bus.chStatus[8*i +: 4];
        sel_data = bus.chOutputData[DW*i +: DW];
      end
    end
  end

  // ---------------- command FSM ----------------
  always_ff @(posedge masterClock) begin
    if (reset) cmd_state <= C_IDLE;
    else       cmd_state <= cmd_next;
  end

  always_comb begin
    cmd_next = cmd_state;
    case (cmd_state)
      C_IDLE: if (bus.dataReceived) cmd_next = idx_valid ? C_WAIT : C_PUSH;
      C_WAIT: if (sel_done || timer == TIMEOUT_LAST) cmd_next = C_PUSH;
      C_PUSH: if (fifo_push) cmd_next = C_IDLE;
      default: cmd_next = C_IDLE;
    endcase
  end

  always_comb begin
    accept    = (cmd_state == C_IDLE) && bus.dataReceived;
    done_hit  = (cmd_state == C_WAIT) && sel_done;
    tmo_hit   = (cmd_state == C_WAIT) && !sel_done && (timer == TIMEOUT_LAST);
    // a pop in the same cycle frees the slot being written
    fifo_push = (cmd_state == C_PUSH) && (!fifo_full || fifo_pop);
  end

  always_ff @(posedge masterClock) begin
    if (reset) begin
      clear_dr_q   <= 1'b0;
      ch_start_q   <= '0;
      ch_control_q <= 8'h00;
      ch_input_q   <= '0;
      busy_q       <= 1'b0;
      cur_idx      <= 4'h0;
      timer        <= '0;
      resp_tag     <= 8'h00;
      resp_data    <= '0;
    end else begin
      clear_dr_q <= accept;
      ch_start_q <= '0;
      if (accept) begin
        ch_control_q <= bus.control;
        ch_input_q   <= bus.inputData;
        cur_idx      <= bus.control[3:0];
        timer        <= '0;
        if (idx_valid) begin
          ch_start_q <= start_onehot;
          busy_q     <= 1'b1;
        end else begin
          resp_tag  <= 8'hFF;
          resp_data <= bus.inputData;
        end
      end
      if (cmd_state == C_WAIT && !done_hit && !tmo_hit) timer <= timer + 1'b1;
      if (done_hit) begin
        resp_tag  <= {cur_idx, sel_code};
        resp_data <= sel_data;
      end else if (tmo_hit) begin
        resp_tag  <= {cur_idx, 4'hE};
        resp_data <= '0;
      end
      if (fifo_push) busy_q <= 1'b0;
    end
  end

  // ---------------- response FIFO ----------------
  always_ff @(posedge masterClock) begin
    if (fifo_push) fifo_mem[wr_ptr] <= {resp_tag, resp_data};
  end

  always_ff @(posedge masterClock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge masterClock) begin
    if (reset) tx_state <= T_IDLE;
    else       tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_IDLE: if (!fifo_empty && !bus.transmitting) tx_next = T_REQ;
      T_REQ:  if (bus.transmitting) tx_next = T_BUSY;
      T_BUSY: if (!bus.transmitting) tx_next = T_IDLE;
      default: tx_next = T_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop = (tx_state == T_IDLE) && !fifo_empty && !bus.transmitting;
  end

  // status/outputData are loaded together with the txRequest pulse and held
  // until the next pop.
  always_ff @(posedge masterClock) begin
    if (reset) begin
      tx_request_q <= 1'b0;
      status_q     <= 8'h00;
      output_q     <= '0;
    end else begin
      tx_request_q <= fifo_pop;
      if (fifo_pop) {status_q, output_q} <= fifo_mem[rd_ptr];
    end
  end

  assign bus.clearDR     = clear_dr_q;
  assign bus.chStart     = ch_start_q;
  assign bus.chControl   = ch_control_q;
  assign bus.chInputData = ch_input_q;
  assign bus.busy        = busy_q;
  assign bus.txRequest   = tx_request_q;
  assign bus.status      = status_q;
  assign bus.outputData  = output_q;

endmodule

// File: tb/tb_sandbox_channel_router.sv
// ---------------------------------------------------------------------------
// tb_sandbox_channel_router
// Directed bench for sandbox_channel_router with WIDTH=4, CHANNELS=4,
// DEPTH=2, TIMEOUT=100. Acts as host, UART transmitter and channel
// processes from a single initial block.
// ---------------------------------------------------------------------------
module tb_sandbox_channel_router;

  logic clk;
  logic rst;

  sandbox_channel_router_if #(.WIDTH(4), .CHANNELS(4)) bus ();

  sandbox_channel_router #(
    .WIDTH(4), .CHANNELS(4), .DEPTH(2), .TIMEOUT(100)
  ) dut (
    .masterClock (clk),
    .reset       (rst),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_tx  = 0;
  int   n_clr = 0;
  int   tx0, clr0;
  logic auto_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock; sample 1ns after the edge, count pulses, host drops DR on
  // acknowledge, optional channel auto-completion one cycle after chStart
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.txRequest) n_tx++;
    if (bus.clearDR) begin
      n_clr++;
      bus.dataReceived = 1'b0;
    end
    bus.chDone = auto_done ? bus.chStart : 4'b0000;
  endtask

  task automatic issue(input string tag, input logic [7:0] ctrl, input logic [31:0] data);
    int c0;
    int k;
    c0 = n_clr;
    k = 0;
    bus.control = ctrl;
    bus.inputData = data;
    bus.dataReceived = 1'b1;
    while (n_clr == c0 && k < 20) begin
      step();
      k++;
    end
    chk(tag, 64'(n_clr - c0), 64'd1);
  endtask

  task automatic wait_tx(input string tag, input logic [7:0] st, input logic [31:0] data);
    int k;
    k = 0;
    while (!bus.txRequest && k < 50) begin
      step();
      k++;
    end
    chk({tag, "_txreq"}, 64'(bus.txRequest), 64'd1);
    chk({tag, "_status"}, 64'(bus.status), 64'(st));
    chk({tag, "_data"}, 64'(bus.outputData), 64'(data));
  endtask

  task automatic xmit();
    bus.transmitting = 1'b1;
    repeat (3) step();
    bus.transmitting = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    bus.dataReceived = 1'b0;
    bus.control      = 8'h00;
    bus.inputData    = 32'h0;
    bus.transmitting = 1'b0;
    bus.chDone       = 4'b0000;
    bus.chStatus     = 32'h0;
    bus.chOutputData = 128'h0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // reset state
    chk("rst_clearDR", 64'(bus.clearDR), 64'd0);
    chk("rst_txRequest", 64'(bus.txRequest), 64'd0);
    chk("rst_status", 64'(bus.status), 64'h0);
    chk("rst_outputData", 64'(bus.outputData), 64'h0);
    chk("rst_chStart", 64'(bus.chStart), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_chControl", 64'(bus.chControl), 64'h0);
    chk("rst_chInputData", 64'(bus.chInputData), 64'h0);

    // command to channel 2
    bus.control = 8'h02;
    bus.inputData = 32'hDEADBEEF;
    bus.dataReceived = 1'b1;
    step();
    chk("a_clearDR", 64'(bus.clearDR), 64'd1);
    chk("a_chStart", 64'(bus.chStart), 64'b0100);
    chk("a_chInputData", 64'(bus.chInputData), 64'hDEADBEEF);
    chk("a_chControl", 64'(bus.chControl), 64'h02);
    chk("a_busy", 64'(bus.busy), 64'd1);
    step();
    chk("a_chStart_pulse", 64'(bus.chStart), 64'h0);
    chk("a_clearDR_pulse", 64'(bus.clearDR), 64'd0);
    bus.chStatus[23:16] = 8'h05;
    bus.chOutputData[95:64] = 32'h12345678;
    bus.chStatus[7:0] = 8'h0C;
    bus.chDone = 4'b0001;   // wrong channel
    step();
    step();
    chk("a_other_ch_busy", 64'(bus.busy), 64'd1);
    chk("a_other_ch_tx", 64'(n_tx), 64'd0);
    bus.chDone = 4'b0100;
    step();
    wait_tx("a", 8'h25, 32'h12345678);
    chk("a_busy_done", 64'(bus.busy), 64'd0);
    xmit();
    repeat (5) step();
    chk("a_tx_once", 64'(n_tx), 64'd1);

    // out-of-range channel: echo
    bus.control = 8'h07;
    bus.inputData = 32'hCAFEF00D;
    bus.dataReceived = 1'b1;
    step();
    chk("b_clearDR", 64'(bus.clearDR), 64'd1);
    chk("b_chStart", 64'(bus.chStart), 64'h0);
    wait_tx("b", 8'hFF, 32'hCAFEF00D);
    xmit();

    // timeout on channel 1
    tx0 = n_tx;
    bus.control = 8'h01;
    bus.inputData = 32'h0;
    bus.dataReceived = 1'b1;
    step();
    chk("c_chStart", 64'(bus.chStart), 64'b0010);
    repeat (99) step();
    chk("c_busy_100", 64'(bus.busy), 64'd1);
    chk("c_no_tx_yet", 64'(n_tx), 64'(tx0));
    step();
    chk("c_busy_push", 64'(bus.busy), 64'd1);
    step();
    chk("c_busy_clear", 64'(bus.busy), 64'd0);
    wait_tx("c", 8'h1E, 32'h0);
    xmit();
    bus.chStatus[15:8] = 8'h33;
    bus.chDone = 4'b0010;   // late completion
    step();
    repeat (10) step();
    chk("c_late_done_tx", 64'(n_tx), 64'(tx0 + 1));
    chk("c_late_done_busy", 64'(bus.busy), 64'd0);

    // FIFO full with transmitter held busy
    auto_done = 1'b1;
    bus.transmitting = 1'b1;
    tx0 = n_tx;
    bus.chStatus[7:0] = 8'h01; bus.chOutputData[31:0] = 32'hA1;
    issue("d_acc1", 8'h00, 32'h1);
    repeat (4) step();
    bus.chStatus[7:0] = 8'h02; bus.chOutputData[31:0] = 32'hA2;
    issue("d_acc2", 8'h00, 32'h2);
    repeat (4) step();
    bus.chStatus[7:0] = 8'h03; bus.chOutputData[31:0] = 32'hA3;
    issue("d_acc3", 8'h00, 32'h3);
    repeat (6) step();
    chk("d_stall_busy", 64'(bus.busy), 64'd1);
    bus.chStatus[7:0] = 8'h04; bus.chOutputData[31:0] = 32'hA4;
    clr0 = n_clr;
    bus.control = 8'h00;
    bus.inputData = 32'h4;
    bus.dataReceived = 1'b1;
    repeat (10) step();
    chk("d_no_ack4", 64'(n_clr), 64'(clr0));
    chk("d_no_tx", 64'(n_tx), 64'(tx0));
    bus.transmitting = 1'b0;
    wait_tx("d1", 8'h01, 32'hA1);
    xmit();
    wait_tx("d2", 8'h02, 32'hA2);
    xmit();
    wait_tx("d3", 8'h03, 32'hA3);
    xmit();
    wait_tx("d4", 8'h04, 32'hA4);
    xmit();
    chk("d_ack4", 64'(n_clr), 64'(clr0 + 1));
    chk("d_tx_count", 64'(n_tx), 64'(tx0 + 4));
    auto_done = 1'b0;

    // reset during WAIT
    issue("e_acc", 8'h03, 32'h77);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("e_busy", 64'(bus.busy), 64'd0);
    chk("e_chStart", 64'(bus.chStart), 64'h0);
    chk("e_chControl", 64'(bus.chControl), 64'h0);
    chk("e_chInputData", 64'(bus.chInputData), 64'h0);
    tx0 = n_tx;
    bus.chStatus[31:24] = 8'h09;
    bus.chDone = 4'b1000;
    step();
    repeat (8) step();
    chk("e_late_done_tx", 64'(n_tx), 64'(tx0));
    chk("e_late_done_busy", 64'(bus.busy), 64'd0);

    // reset during T_BUSY with one entry still queued
    bus.transmitting = 1'b1;
    issue("f_acc1", 8'h0F, 32'h11);
    repeat (3) step();
    issue("f_acc2", 8'h0F, 32'h22);
    repeat (3) step();
    bus.transmitting = 1'b0;
    wait_tx("f1", 8'hFF, 32'h11);
    bus.transmitting = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.transmitting = 1'b0;
    tx0 = n_tx;
    repeat (10) step();
    chk("f_no_tx", 64'(n_tx), 64'(tx0));
    chk("f_status", 64'(bus.status), 64'h0);
    chk("f_outputData", 64'(bus.outputData), 64'h0);
    issue("f_acc3", 8'h0F, 32'h55);
    wait_tx("f2", 8'hFF, 32'h55);
    xmit();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
